// File: rtl/cv32e40p_obi_responder.sv
// OBI memory responder model for the CV32E40P core interfaces.
// Grants after a programmable number of request cycles and returns a
// response a fixed number of cycles after each handshake, with at most
// two transactions outstanding. It also flags initiators that change the
// address phase, or drop req_i, before they are granted.
// Optional feature: define CV32E40P_OBI_RESP_ERR_EN to report accesses at or
// beyond MEM_WORDS*4 as error responses. Without it, addresses wrap.
module cv32e40p_obi_responder #(
    parameter int unsigned GNT_STALL  = 0,
    parameter int unsigned RVALID_LAT = 1,
    parameter int unsigned MEM_WORDS  = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        protocol_err_o
);

    localparam int unsigned IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned STALL_W = (GNT_STALL > 0) ? $clog2(GNT_STALL + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(GNT_STALL);
    localparam logic [2:0] LAT_INIT = 3'(RVALID_LAT - 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               gnt_int;
    logic               hs;
    logic [IDX_W-1:0]   mem_idx;
    logic               addr_err;
    logic               mem_we;
    logic [31:0]        mem_q [MEM_WORDS];

    // Two-entry response queue; entry 0 is always the oldest.
    logic [1:0]  q_vld_q, q_vld_d;
    logic [2:0]  q_cnt_q [2];
    logic [2:0]  q_cnt_d [2];
    logic [31:0] q_dat_q [2];
    logic [31:0] q_dat_d [2];
    logic [1:0]  q_err_q, q_err_d;

    // Address-phase snapshot for spotting initiator violations.
    logic        pend_q, pend_d;
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic        perr_q, perr_d;
    logic        viol;

    logic        unused_addr;

    // Internal grant excludes rst_ni so the reset net stays purely asynchronous;
    // flops are held in reset anyway while rst_ni is low.
    assign gnt_int = req_i & (stall_q == STALL_MAX) & ~q_vld_q[1];
    assign gnt_o   = gnt_int & rst_ni;
    assign hs      = req_i & gnt_int;
    assign mem_idx = addr_i[2 +: IDX_W];

`ifdef CV32E40P_OBI_RESP_ERR_EN
    assign addr_err = (addr_i >= 32'(MEM_WORDS * 4));
`else
    assign addr_err = 1'b0;
`endif

    assign unused_addr = ^{addr_i[31:2+IDX_W], addr_i[1:0]};
    assign mem_we      = hs & we_i & ~addr_err;

    assign rvalid_o       = q_vld_q[0] & (q_cnt_q[0] == 3'd0);
    assign rdata_o        = rvalid_o ? q_dat_q[0] : 32'h0;
    assign err_o          = rvalid_o & q_err_q[0];
    assign protocol_err_o = perr_q;

    // Stall counter: counts ungranted request cycles, saturating at GNT_STALL.
    always_comb begin
        stall_d = stall_q;
        if (!req_i || hs) begin
            stall_d = '0;
        end else if (stall_q != STALL_MAX) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    // Response queue: age entries, pop the head on rvalid, append on handshake.
    always_comb begin
        q_vld_d = q_vld_q;
        q_cnt_d = q_cnt_q;
        q_dat_d = q_dat_q;
        q_err_d = q_err_q;
        for (int i = 0; i < 2; i++) begin
            if (q_vld_q[i] && (q_cnt_q[i] != 3'd0)) begin
                q_cnt_d[i] = q_cnt_q[i] - 3'd1;
            end
        end
        if (rvalid_o) begin
            q_vld_d[0] = q_vld_d[1];
            q_cnt_d[0] = q_cnt_d[1];
            q_dat_d[0] = q_dat_d[1];
            q_err_d[0] = q_err_d[1];
            q_vld_d[1] = 1'b0;
        end
        // Read data is sampled from the array as it stands before this edge.
        if (hs) begin
            if (!q_vld_d[0]) begin
                q_vld_d[0] = 1'b1;
                q_cnt_d[0] = LAT_INIT;
                q_dat_d[0] = (we_i || addr_err) ? 32'h0 : mem_q[mem_idx];
                q_err_d[0] = addr_err;
            end else begin
                q_vld_d[1] = 1'b1;
                q_cnt_d[1] = LAT_INIT;
                q_dat_d[1] = (we_i || addr_err) ? 32'h0 : mem_q[mem_idx];
                q_err_d[1] = addr_err;
            end
        end
    end

    // Violation: last cycle was an ungranted request and the address phase moved.
    always_comb begin
        viol = pend_q & (~req_i | (addr_i != addr_q) | (we_i != we_q) |
                         (be_i != be_q) | (wdata_i != wdata_q));
        perr_d = perr_q | viol;
        pend_d = req_i & ~gnt_int;
    end

    // Control and queue state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
            q_vld_q <= '0;
            q_err_q <= '0;
            for (int i = 0; i < 2; i++) begin
                q_cnt_q[i] <= '0;
                q_dat_q[i] <= '0;
            end
            pend_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            q_vld_q <= q_vld_d;
            q_cnt_q <= q_cnt_d;
            q_dat_q <= q_dat_d;
            q_err_q <= q_err_d;
            pend_q  <= pend_d;
            addr_q  <= addr_i;
            we_q    <= we_i;
            be_q    <= be_i;
            wdata_q <= wdata_i;
            perr_q  <= perr_d;
        end
    end

    // Word array with per-byte write enables, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < MEM_WORDS; w++) begin
                mem_q[w] <= '0;
            end
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_obi_responder.sv
// Bench for cv32e40p_obi_responder: three instances with different
// stall/latency settings, directed scenarios with literal expectations and a
// randomized protocol-legal phase, all checked every cycle against a model
// that tracks responses by absolute due cycle.
module tb_cv32e40p_obi_responder;

`ifdef CV32E40P_OBI_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req    [3];
    logic        we     [3];
    logic [31:0] addr   [3];
    logic [3:0]  be     [3];
    logic [31:0] wdata  [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];
    logic        perr   [3];

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int burst_wait [4];

    cv32e40p_obi_responder #(.GNT_STALL(0), .RVALID_LAT(1), .MEM_WORDS(16)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
        .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .err_o(err[0]), .protocol_err_o(perr[0]));

    cv32e40p_obi_responder #(.GNT_STALL(2), .RVALID_LAT(3), .MEM_WORDS(16)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
        .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .err_o(err[1]), .protocol_err_o(perr[1]));

    cv32e40p_obi_responder #(.GNT_STALL(0), .RVALID_LAT(3), .MEM_WORDS(16)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
        .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
        .rdata_o(rdata[2]), .err_o(err[2]), .protocol_err_o(perr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gs_of(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] mem_m  [3][16];
    int          due_m  [3][2];
    logic [31:0] dat_m  [3][2];
    logic        erq_m  [3][2];
    int          n_m    [3];
    int          stall_m[3];
    logic        perr_m [3];
    logic        pp_m   [3];
    logic [31:0] pa_m   [3];
    logic [31:0] pd_m   [3];
    logic        pw_m   [3];
    logic [3:0]  pb_m   [3];

    initial begin
        logic        eg, ev, ee, viol, oor;
        logic [31:0] ed;
        int          last_due, widx, due;
        forever begin
            @(negedge clk);
            cyc_n++;
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    chk($sformatf("gnt%0d_rst", i), 32'(gnt[i]), 32'd0);
                    chk($sformatf("rvalid%0d_rst", i), 32'(rvalid[i]), 32'd0);
                    chk($sformatf("rdata%0d_rst", i), rdata[i], 32'd0);
                    chk($sformatf("err%0d_rst", i), 32'(err[i]), 32'd0);
                    chk($sformatf("perr%0d_rst", i), 32'(perr[i]), 32'd0);
                    for (int w = 0; w < 16; w++) mem_m[i][w] = 32'h0;
                    n_m[i] = 0;
                    stall_m[i] = 0;
                    perr_m[i] = 1'b0;
                    pp_m[i] = 1'b0;
                end else begin
                    eg = req[i] && (stall_m[i] >= gs_of(i)) && (n_m[i] < 2);
                    ev = (n_m[i] > 0) && (due_m[i][0] == cyc_n);
                    ed = ev ? dat_m[i][0] : 32'h0;
                    ee = ev && erq_m[i][0];
                    chk($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(eg));
                    chk($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'(ev));
                    chk($sformatf("rdata%0d", i), rdata[i], ed);
                    chk($sformatf("err%0d", i), 32'(err[i]), 32'(ee));
                    chk($sformatf("perr%0d", i), 32'(perr[i]), 32'(perr_m[i]));

                    viol = pp_m[i] && (!req[i] || addr[i] != pa_m[i] || we[i] != pw_m[i] ||
                                       be[i] != pb_m[i] || wdata[i] != pd_m[i]);
                    if (viol) perr_m[i] = 1'b1;
                    pp_m[i] = req[i] && !eg;
                    pa_m[i] = addr[i];
                    pw_m[i] = we[i];
                    pb_m[i] = be[i];
                    pd_m[i] = wdata[i];

                    last_due = (n_m[i] > 0) ? due_m[i][n_m[i]-1] : 0;
                    if (ev) begin
                        due_m[i][0] = due_m[i][1];
                        dat_m[i][0] = dat_m[i][1];
                        erq_m[i][0] = erq_m[i][1];
                        n_m[i]--;
                    end
                    if (eg) begin
                        oor  = ERR_EN && (addr[i] >= 32'd64);
                        widx = int'((addr[i] >> 2) % 32'd16);
                        due  = cyc_n + lat_of(i);
                        if (due <= last_due) due = last_due + 1;
                        due_m[i][n_m[i]] = due;
                        dat_m[i][n_m[i]] = (we[i] || oor) ? 32'h0 : mem_m[i][widx];
                        erq_m[i][n_m[i]] = oor;
                        n_m[i]++;
                        if (we[i] && !oor) begin
                            for (int b = 0; b < 4; b++) begin
                                if (be[i][b]) mem_m[i][widx][8*b +: 8] = wdata[i][8*b +: 8];
                            end
                        end
                    end
                    if (!req[i] || eg) stall_m[i] = 0;
                    else if (stall_m[i] < gs_of(i)) stall_m[i]++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single transaction, waits for grant and response.
    task automatic do_xfer(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d, output logic [31:0] rd, output logic er,
                           output int gw, output int lt);
        logic got;
        req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
        gw = 0; lt = 0; got = 1'b0; rd = 32'hx; er = 1'bx;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (gnt[i]) got = 1'b1; else gw++;
            cyc();
        end
        req[i] = 1'b0;
        if (!got) chk($sformatf("timeout_gnt%0d", i), 32'd0, 32'd1);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            lt++;
            if (rvalid[i]) begin
                got = 1'b1; rd = rdata[i]; er = err[i];
            end
            cyc();
        end
        if (!got) chk($sformatf("timeout_rvalid%0d", i), 32'd0, 32'd1);
    endtask

    // Back-to-back reads, each held until granted; returns after last handshake.
    task automatic read_burst(input int i, input int nt, input logic [31:0] base);
        logic got;
        for (int k = 0; k < nt; k++) begin
            req[i] = 1'b1; we[i] = 1'b0; addr[i] = base + 32'(4 * k); be[i] = 4'hF; wdata[i] = 32'h0;
            burst_wait[k] = 0; got = 1'b0;
            for (int n = 0; n < 50 && !got; n++) begin
                @(negedge clk);
                if (gnt[i]) got = 1'b1; else burst_wait[k]++;
                cyc();
            end
            if (!got) chk($sformatf("timeout_burst%0d", i), 32'd0, 32'd1);
        end
        req[i] = 1'b0;
    endtask

    // Protocol-legal random initiator.
    task automatic rand_drive(input int i, input int ncyc);
        logic granted;
        granted = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            if (!req[i] || granted) begin
                if ($urandom_range(0, 2) != 0) begin
                    req[i]   = 1'b1;
                    we[i]    = 1'($urandom_range(0, 1));
                    addr[i]  = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
                    be[i]    = 4'($urandom_range(0, 15));
                    wdata[i] = $urandom;
                end else begin
                    req[i] = 1'b0;
                end
            end
            @(negedge clk);
            granted = gnt[i];
            cyc();
        end
        req[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] rd;
        logic        er;
        int          gw, lt, cnt;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; be[i] = 4'h0; wdata[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // Same-cycle grant, one-cycle read latency.
        do_xfer(0, 1'b1, 32'h8, 4'hF, 32'hDEADBEEF, rd, er, gw, lt);
        chk("wr_gnt_wait", 32'(gw), 32'd0);
        chk("wr_rdata_zero", rd, 32'h0);
        do_xfer(0, 1'b0, 32'h8, 4'hF, 32'h0, rd, er, gw, lt);
        chk("rd_gnt_wait", 32'(gw), 32'd0);
        chk("rd_latency", 32'(lt), 32'd1);
        chk("rd_deadbeef", rd, 32'hDEADBEEF);

        // Byte-enable merge.
        do_xfer(0, 1'b1, 32'h4, 4'hF, 32'h11223344, rd, er, gw, lt);
        do_xfer(0, 1'b1, 32'h4, 4'b0010, 32'hAABBCCDD, rd, er, gw, lt);
        do_xfer(0, 1'b0, 32'h5, 4'hF, 32'h0, rd, er, gw, lt);
        chk("be_merge", rd, 32'h1122CC44);

        // Grant stall of two cycles, then an address change before grant.
        do_xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, rd, er, gw, lt);
        chk("stall_gnt_wait", 32'(gw), 32'd2);
        chk("stall_latency", 32'(lt), 32'd3);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0; be[1] = 4'hF; wdata[1] = 32'h0;
        @(negedge clk);
        chk("perr1_pre", 32'(perr[1]), 32'd0);
        cyc();
        addr[1] = 32'h4;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("perr1_set", 32'(perr[1]), 32'd1);
        chk("gnt1_third", 32'(gnt[1]), 32'd1);
        cyc();
        req[1] = 1'b0;
        repeat (6) cyc();
        @(negedge clk);
        chk("perr1_sticky", 32'(perr[1]), 32'd1);
        cyc();

        // Three back-to-back reads with latency 3: third waits for the first pop.
        read_burst(2, 3, 32'h0);
        chk("burst_wait0", 32'(burst_wait[0]), 32'd0);
        chk("burst_wait1", 32'(burst_wait[1]), 32'd0);
        chk("burst_wait2", 32'(burst_wait[2]), 32'd2);
        repeat (8) cyc();

        // Reset with two reads in flight.
        do_xfer(2, 1'b1, 32'h10, 4'hF, 32'h12345678, rd, er, gw, lt);
        read_burst(2, 2, 32'h10);
        rst_n = 1'b0;
        req[0] = 1'b1; addr[0] = 32'h0; we[0] = 1'b0; be[0] = 4'hF;
        @(negedge clk);
        chk("rst_gnt0", 32'(gnt[0]), 32'd0);
        cyc();
        cyc();
        req[0] = 1'b0;
        rst_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rvalid[2]) cnt++;
            cyc();
        end
        chk("no_rvalid_after_rst", 32'(cnt), 32'd0);
        chk("perr1_cleared", 32'(perr[1]), 32'd0);
        do_xfer(2, 1'b0, 32'h10, 4'hF, 32'h0, rd, er, gw, lt);
        chk("mem_cleared", rd, 32'h0);

        // Out-of-range access.
        do_xfer(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, rd, er, gw, lt);
        do_xfer(0, 1'b0, 32'h40, 4'hF, 32'h0, rd, er, gw, lt);
        if (ERR_EN) begin
            chk("oor_err", 32'(er), 32'd1);
            chk("oor_rdata", rd, 32'h0);
        end else begin
            chk("wrap_err", 32'(er), 32'd0);
            chk("wrap_rdata", rd, 32'hCAFEF00D);
        end

        // Randomized traffic on all instances.
        fork
            rand_drive(0, 600);
            rand_drive(1, 600);
            rand_drive(2, 600);
        join
        repeat (12) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
